// File: rtl/cacheline_burst_adapter.sv
// Bridges one 256-bit cache line fill/writeback to a 4-beat 64-bit burst memory port.
// Optional completion counters are built when CACHELINE_ADAPTER_PERF_CNT_EN is defined.
module cacheline_burst_adapter #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_burst  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [s_line-1:0]   line_i,
  output logic [s_line-1:0]   line_o,
  input  logic [31:0]         address_i,
  input  logic                read_i,
  input  logic                write_i,
  output logic                resp_o,
  input  logic [s_burst-1:0]  burst_i,
  output logic [s_burst-1:0]  burst_o,
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i,
  output logic [31:0]         rd_count_o,
  output logic [31:0]         wr_count_o
);

  localparam int num_beats = s_line / s_burst;
  localparam int cnt_w     = $clog2(num_beats);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } state_t;

  state_t              state;
  logic [cnt_w-1:0]    cnt;
  logic [s_line-1:0]   buffer;
  logic [31:0]         line_addr;

  // Offset bits are discarded; bursts always start on a line boundary.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address_i[s_offset-1:0];
  assign line_addr = {address_i[31:s_offset], {s_offset{1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      buffer    <= '0;
      line_o    <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      resp_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (write_i) begin
            state     <= WR_BURST;
            buffer    <= line_i;
            address_o <= line_addr;
            write_o   <= 1'b1;
          end else if (read_i) begin
            state     <= RD_BURST;
            address_o <= line_addr;
            read_o    <= 1'b1;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            buffer[cnt*s_burst +: s_burst] <= burst_i;
            if (cnt == last_beat) begin
              // The final beat is the top slice, so the line is complete with it.
              line_o <= {burst_i, buffer[s_line-s_burst-1:0]};
              state  <= RD_DONE;
              read_o <= 1'b0;
              resp_o <= 1'b1;
              cnt    <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RD_DONE: state <= IDLE;
        WR_BURST: begin
          if (resp_i) begin
            if (cnt == last_beat) begin
              state   <= WR_DONE;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WR_DONE: state <= IDLE;
        default: begin
          state   <= IDLE;
          read_o  <= 1'b0;
          write_o <= 1'b0;
        end
      endcase
    end
  end

  // write_o is high exactly while a writeback beat is being offered.
  assign burst_o = write_o ? buffer[cnt*s_burst +: s_burst] : '0;

`ifdef CACHELINE_ADAPTER_PERF_CNT_EN
  logic [31:0] rd_count_q;
  logic [31:0] wr_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      if (state == RD_DONE) rd_count_q <= rd_count_q + 32'd1;
      if (state == WR_DONE) wr_count_q <= wr_count_q + 32'd1;
    end
  end

  assign rd_count_o = rd_count_q;
  assign wr_count_o = wr_count_q;
`else
  assign rd_count_o = '0;
  assign wr_count_o = '0;
`endif

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Directed self-checking bench for cacheline_burst_adapter.
module tb_cacheline_burst_adapter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic [31:0]  address_i = '0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic         resp_o;
  logic [63:0]  burst_i = '0;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i = 1'b0;
  logic [31:0]  rd_count_o;
  logic [31:0]  wr_count_o;

  int nchk = 0;
  int nfail = 0;
  logic [255:0] last_fill = '0;

  cacheline_burst_adapter dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i),
    .rd_count_o(rd_count_o), .wr_count_o(wr_count_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives a fill with back-to-back beats; optionally scrambles address_i mid-burst.
  task automatic run_fill(input logic [31:0] addr, input logic [255:0] beats,
                          input bit scramble, input string name);
    logic [31:0] exp_addr;
    exp_addr = addr & 32'hFFFF_FFE0;
    address_i = addr;
    read_i = 1'b1;
    resp_i = 1'b0;
    cyc();
    for (int b = 0; b < 4; b++) begin
      nchk++;
      if (read_o !== 1'b1 || resp_o !== 1'b0) begin
        nfail++;
        $display("FAIL %s beat%0d read_o/resp_o: got %b/%b want 1/0", name, b, read_o, resp_o);
      end
      nchk++;
      if (address_o !== exp_addr) begin
        nfail++;
        $display("FAIL %s beat%0d address_o: got %h want %h", name, b, address_o, exp_addr);
      end
      burst_i = beats[b*64 +: 64];
      resp_i = 1'b1;
      if (scramble) address_i = ~addr;
      cyc();
    end
    resp_i = 1'b0;
    burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    nchk++;
    if (resp_o !== 1'b1 || read_o !== 1'b0) begin
      nfail++;
      $display("FAIL %s done resp_o/read_o: got %b/%b want 1/0", name, resp_o, read_o);
    end
    nchk++;
    if (line_o !== beats) begin
      nfail++;
      $display("FAIL %s line_o: got %h want %h", name, line_o, beats);
    end
    read_i = 1'b0;
    cyc();
    nchk++;
    if (resp_o !== 1'b0) begin
      nfail++;
      $display("FAIL %s resp_o pulse width: got %b want 0", name, resp_o);
    end
    last_fill = beats;
  endtask

  // Drives a writeback; with gap set, resp_i is low for one cycle before each beat.
  task automatic run_wb(input logic [255:0] line, input bit gap, input string name);
    line_i = line;
    write_i = 1'b1;
    resp_i = 1'b0;
    cyc();
    line_i = '0;
    for (int b = 0; b < 4; b++) begin
      if (gap) begin
        resp_i = 1'b0;
        cyc();
        nchk++;
        if (burst_o !== line[b*64 +: 64]) begin
          nfail++;
          $display("FAIL %s stall beat%0d burst_o: got %h want %h", name, b, burst_o, line[b*64 +: 64]);
        end
      end
      nchk++;
      if (write_o !== 1'b1 || burst_o !== line[b*64 +: 64] || resp_o !== 1'b0) begin
        nfail++;
        $display("FAIL %s beat%0d write_o/burst_o/resp_o: got %b/%h/%b want 1/%h/0",
                 name, b, write_o, burst_o, resp_o, line[b*64 +: 64]);
      end
      resp_i = 1'b1;
      cyc();
    end
    resp_i = 1'b0;
    nchk++;
    if (resp_o !== 1'b1 || write_o !== 1'b0) begin
      nfail++;
      $display("FAIL %s done resp_o/write_o: got %b/%b want 1/0", name, resp_o, write_o);
    end
    nchk++;
    if (line_o !== last_fill) begin
      nfail++;
      $display("FAIL %s line_o disturbed: got %h want %h", name, line_o, last_fill);
    end
    write_i = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    nchk++;
    if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0) begin
      nfail++;
      $display("FAIL reset ctrl: got resp/read/write %b%b%b want 000", resp_o, read_o, write_o);
    end
    nchk++;
    if (line_o !== 256'h0 || burst_o !== 64'h0 || address_o !== 32'h0) begin
      nfail++;
      $display("FAIL reset data: got line %h burst %h addr %h want 0", line_o, burst_o, address_o);
    end
    nchk++;
    if (rd_count_o !== 32'h0 || wr_count_o !== 32'h0) begin
      nfail++;
      $display("FAIL reset counters: got %h/%h want 0/0", rd_count_o, wr_count_o);
    end
    rst = 1'b0;
    cyc();
    nchk++;
    if (read_o !== 1'b0 || write_o !== 1'b0) begin
      nfail++;
      $display("FAIL post-reset idle: got read/write %b%b want 00", read_o, write_o);
    end
  endtask

  task automatic test_fill();
    run_fill(32'h1234_5678, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 1'b0, "fill");
  endtask

  task automatic test_writeback();
    run_wb({{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 1'b1, "writeback");
  endtask

  task automatic test_simultaneous();
    int nresp = 0;
    int overlap = 0;
    int first = 0;
    int rd_idx = 0;
    logic [255:0] exp_line;
    exp_line = {64'hFEED_0000_0000_0003, 64'hFEED_0000_0000_0002,
                64'hFEED_0000_0000_0001, 64'hFEED_0000_0000_0000};
    address_i = 32'h0000_2010;
    line_i = {4{64'h0123_4567_89AB_CDEF}};
    read_i = 1'b1;
    write_i = 1'b1;
    resp_i = 1'b1;
    cyc();
    for (int i = 0; i < 30 && nresp < 2; i++) begin
      if (read_o && write_o) overlap++;
      if (resp_o && (read_o || write_o)) overlap++;
      if (first == 0 && write_o) first = 1;
      if (first == 0 && read_o) first = 2;
      if (resp_o) begin
        nresp++;
        if (nresp == 1) write_i = 1'b0;
        else read_i = 1'b0;
      end
      if (read_o) begin
        burst_i = 64'hFEED_0000_0000_0000 + 64'(rd_idx);
        rd_idx++;
      end
      if (nresp < 2) cyc();
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    write_i = 1'b0;
    nchk++;
    if (nresp != 2) begin
      nfail++;
      $display("FAIL simul resp count (timeout bound): got %0d want 2", nresp);
    end
    nchk++;
    if (overlap != 0) begin
      nfail++;
      $display("FAIL simul overlap cycles: got %0d want 0", overlap);
    end
    nchk++;
    if (first != 1) begin
      nfail++;
      $display("FAIL simul first burst (1=write,2=read): got %0d want 1", first);
    end
    nchk++;
    if (line_o !== exp_line) begin
      nfail++;
      $display("FAIL simul line_o: got %h want %h", line_o, exp_line);
    end
    last_fill = exp_line;
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    address_i = 32'h0000_1000;
    read_i = 1'b1;
    cyc();
    for (int b = 0; b < 3; b++) begin
      burst_i = {16{4'(b + 5)}};
      resp_i = 1'b1;
      cyc();
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    rst = 1'b1;
    #1;
    nchk++;
    if (read_o !== 1'b0 || resp_o !== 1'b0 || address_o !== 32'h0 || line_o !== 256'h0) begin
      nfail++;
      $display("FAIL abort outputs: got read %b resp %b addr %h line %h want all 0",
               read_o, resp_o, address_o, line_o);
    end
    cyc();
    rst = 1'b0;
    cyc();
    nchk++;
    if (resp_o !== 1'b0 || read_o !== 1'b0) begin
      nfail++;
      $display("FAIL abort no completion: got resp/read %b%b want 00", resp_o, read_o);
    end
    last_fill = '0;
    run_fill(32'h0000_1004, {64'h8888_7777_6666_5555, 64'h4444_3333_2222_1111,
                             64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0}, 1'b0, "refill");
  endtask

  task automatic test_idle_and_addr_hold();
    resp_i = 1'b1;
    burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 3; i++) cyc();
    resp_i = 1'b0;
    nchk++;
    if (read_o !== 1'b0 || resp_o !== 1'b0 || line_o !== last_fill) begin
      nfail++;
      $display("FAIL idle resp_i: got read %b resp %b line %h want 0 0 %h",
               read_o, resp_o, line_o, last_fill);
    end
    run_fill(32'h0000_0047, {64'h1, 64'h2, 64'h3, 64'h4}, 1'b1, "addr_hold");
  endtask

  task automatic test_perf();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    last_fill = '0;
    for (int i = 0; i < 3; i++)
      run_fill(32'h100 * i, {4{64'(i + 1)}}, 1'b0, "perf_fill");
    for (int i = 0; i < 2; i++)
      run_wb({4{64'(i + 9)}}, 1'b0, "perf_wb");
`ifdef CACHELINE_ADAPTER_PERF_CNT_EN
    nchk++;
    if (rd_count_o !== 32'd3 || wr_count_o !== 32'd2) begin
      nfail++;
      $display("FAIL perf counts: got rd %0d wr %0d want 3 2", rd_count_o, wr_count_o);
    end
    force dut.rd_count_q = 32'hFFFF_FFFF;
    force dut.wr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.rd_count_q;
    release dut.wr_count_q;
    run_fill(32'h400, {4{64'h77}}, 1'b0, "wrap_fill");
    nchk++;
    if (rd_count_o !== 32'h0 || wr_count_o !== 32'hFFFF_FFFF) begin
      nfail++;
      $display("FAIL perf wrap rd: got rd %h wr %h want 0 ffffffff", rd_count_o, wr_count_o);
    end
    run_wb({4{64'h55}}, 1'b0, "wrap_wb");
    nchk++;
    if (wr_count_o !== 32'h0 || rd_count_o !== 32'h0) begin
      nfail++;
      $display("FAIL perf wrap wr: got rd %h wr %h want 0 0", rd_count_o, wr_count_o);
    end
`else
    nchk++;
    if (rd_count_o !== 32'h0 || wr_count_o !== 32'h0) begin
      nfail++;
      $display("FAIL counters tied off: got rd %h wr %h want 0 0", rd_count_o, wr_count_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_writeback();
    test_simultaneous();
    test_reset_mid_burst();
    test_idle_and_addr_hold();
    test_perf();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/cacheline_burst_adapter.md
Name: cacheline_burst_adapter

Overview:
- Sits between the two-cycle cache's physical-memory port and the off-chip burst memory.
- Converts one 256-bit line fill or writeback into a 4-beat, 64-bit burst transaction.
- Returns a single-cycle completion pulse to the cache control FSM.
- One outstanding transaction at a time; no buffering beyond one line.

Parameters:
- s_offset, 5, byte-offset bits within a line; the address is aligned by zeroing these bits.
- s_line, 256, line width in bits.
- s_burst, 64, burst beat width in bits; num_beats = s_line/s_burst = 4 (derived, localparam).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- line_i  input  256  line to write back, sampled when a write is accepted.
- line_o  output  256  assembled fill line, valid when resp_o=1 and held until the next fill completes.
- address_i  input  32  cache-side physical address.
- read_i  input  1  cache requests a line fill; level, held until resp_o.
- write_i  input  1  cache requests a writeback; level, held until resp_o.
- resp_o  output  1  one-cycle completion pulse.
- burst_i  input  64  memory read beat.
- burst_o  output  64  memory write beat.
- address_o  output  32  line-aligned burst address.
- read_o  output  1  burst read request.
- write_o  output  1  burst write request.
- resp_i  input  1  memory beat handshake; one beat transferred per cycle it is high.
- rd_count_o  output  32  completed fill counter (optional feature).
- wr_count_o  output  32  completed writeback counter (optional feature).

Behaviour:
- Reset: state=IDLE, beat count=0, all outputs 0 (line_o, burst_o, address_o, resp_o, read_o, write_o, counters).
- Reset asserted mid-burst: aborts immediately to IDLE with outputs 0; no resp_o is issued.
- FSM states: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
- IDLE:
  - write_i=1 → WR_BURST; latch line_i into the beat buffer; latch address_o={address_i[31:s_offset], s_offset'b0}.
  - Else read_i=1 → RD_BURST; latch the address the same way.
  - write_i and read_i both high: write wins; read is served after resp_o if still held.
  - resp_i in IDLE is ignored.
- RD_BURST:
  - read_o=1 (registered, first high the cycle after acceptance).
  - Each cycle resp_i=1: burst_i is written to buffer slice [cnt*64 +: 64] and cnt increments. Beat 0 is bits [63:0].
  - resp_i on beat 3 → RD_DONE and cnt wraps to 0.
  - resp_i=0 stalls indefinitely with read_o held.
- RD_DONE: resp_o=1 and read_o=0 for exactly one cycle; line_o=buffer; → IDLE.
- WR_BURST:
  - write_o=1; burst_o = buffer slice [cnt*64 +: 64], stable until resp_i.
  - Beat advances on resp_i; beat 3 accepted → WR_DONE.
- WR_DONE: resp_o=1 and write_o=0 for one cycle; → IDLE.
- Minimum latency at 1 beat/cycle: request seen at cycle 0, read_o/write_o high in cycles 1–4, resp_o in cycle 5.
- read_o and write_o are never high together.
- address_o is stable for the whole burst.
- resp_o never coincides with read_o or write_o.
- Back-to-back requests: IDLE is occupied for at least one cycle after DONE, so a request held through resp_o is re-accepted in that IDLE cycle. The cache must drop read_i/write_i the cycle after resp_o.
- line_o is updated only on fill completion; writebacks do not alter line_o.

Optional Feature:
- Macro: CACHELINE_ADAPTER_PERF_CNT_EN.
- Defined:
  - rd_count_o increments in each RD_DONE cycle; wr_count_o increments in each WR_DONE cycle.
  - Both are 32-bit, wrap at 2^32-1 → 0, and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Fill: address_i=0x1234_5678, read_i=1; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back → address_o=0x1234_5660, read_o high 4 cycles, resp_o in cycle 5, line_o={0x44..,0x33..,0x22..,0x11..}.
- Writeback: line_i={0xDDDD..,0xCCCC..,0xBBBB..,0xAAAA..}, write_i=1, resp_i with 1-cycle gaps → burst_o sequence AAAA,BBBB,CCCC,DDDD, each held until its resp_i; resp_o one cycle after the 4th beat.
- Simultaneous read_i=write_i=1 → write burst first with resp_o; then a read burst (read_i still held) with a second resp_o; read_o and write_o never overlap.
- rst asserted after beat 2 of a fill → next cycle all outputs 0 and state IDLE; a new fill completes normally and line_o holds only the new data.
- resp_i pulsed while idle, plus address_i changed mid-burst → no beat captured while idle; address_o unchanged during the burst.
- With CACHELINE_ADAPTER_PERF_CNT_EN: 3 fills and 2 writebacks → rd_count_o=3, wr_count_o=2; with counters preloaded to 0xFFFF_FFFF via force, one fill → rd_count_o=0.
